uart_rx_frame_collect: RTL and testbench

//  Parametrised asynchronous serial frame receiver for the PCS pack serial links.

---
 rtl/uart_rx_frame_collect.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_frame_collect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_collect.sv
// Asynchronous serial frame receiver: start-edge detect, per-frame bit timing,
// majority-of-3 mid-bit vote, DATA_W payload assembly and stop-bit framing check.
module uart_rx_frame_collect #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_W    = 32,
    parameter int LSB_FIRST = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_uart_rxd,
    input  logic              i_enable,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int HALF = CLK_DIV / 2;
    localparam int BCW  = $clog2(CLK_DIV);
    localparam int BIW  = $clog2(DATA_W + 1);

    localparam logic [BCW-1:0] BC_LAST      = BCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BC_LO        = BCW'(HALF - 1);
    localparam logic [BCW-1:0] BC_MID       = BCW'(HALF);
    localparam logic [BCW-1:0] BC_DEC       = BCW'(HALF + 1);
    localparam logic [BIW-1:0] BI_DATA_LAST = BIW'(DATA_W - 1);
    localparam logic [BIW-1:0] BI_STOP_LAST = BIW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t            state_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;
    logic [BCW-1:0]    bcnt_q;
    logic [BIW-1:0]    bidx_q;
    logic              samp_lo_q;
    logic              samp_mid_q;
    logic              err_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              frame_err_q;
    logic              busy_q;
    logic              start_edge_s;
    logic              decide_s;
    logic              vote_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge qualification, mid-bit vote and next shift-register value.
    always_comb begin
        start_edge_s = prev_q & ~sync2_q & i_enable;
        decide_s     = (bcnt_q == BC_DEC);
        vote_s       = maj3(samp_lo_q, samp_mid_q, sync2_q);
        if (LSB_FIRST != 0) begin
            shift_d = (shift_q >> 1) | (DATA_W'(vote_s) << (DATA_W - 1));
        end else begin
            shift_d = (shift_q << 1) | DATA_W'(vote_s);
        end
    end

    // Frame FSM with bit timing, payload assembly and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            bidx_q      <= '0;
            samp_lo_q   <= 1'b1;
            samp_mid_q  <= 1'b1;
            err_q       <= 1'b0;
            shift_q     <= '1;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != IDLE) begin
                bcnt_q <= (bcnt_q == BC_LAST) ? '0 : bcnt_q + 1'b1;
                if (bcnt_q == BC_LO) begin
                    samp_lo_q <= sync2_q;
                end
                if (bcnt_q == BC_MID) begin
                    samp_mid_q <= sync2_q;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start_edge_s) begin
                        state_q <= START;
                        bcnt_q  <= '0;
                        bidx_q  <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (decide_s) begin
                        // A start bit that votes high was a glitch: drop silently.
                        if (vote_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide_s) begin
                        shift_q <= shift_d;
                        if (bidx_q == BI_DATA_LAST) begin
                            state_q <= STOP;
                            bidx_q  <= '0;
                        end else begin
                            bidx_q <= bidx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (decide_s) begin
                        err_q <= err_q | ~vote_s;
                        // Leave at the mid-stop point so a following start edge is never missed.
                        if (bidx_q == BI_STOP_LAST) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            valid_q     <= 1'b1;
                            data_q      <= shift_q;
                            frame_err_q <= err_q | ~vote_s;
                        end else begin
                            bidx_q <= bidx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_collect.sv
// Bench for uart_rx_frame_collect: default instance plus an 8-bit/LSB-first/2-stop/div-5
// instance, driven with directed and random frames and checked against a frame-level model.
module tb_uart_rx_frame_collect;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n, rxd0, rxd1, en0, en1;
    logic        v0, v1, fe0, fe1, b0, b1;
    logic [31:0] d0;
    logic [7:0]  d1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int leak  = 0;

    int          gc0[$], gc1[$], ec0[$], ec1[$];
    logic [63:0] gd0[$], gd1[$], ed0[$], ed1[$];
    logic        ge0[$], ge1[$], ee0[$], ee1[$];

    uart_rx_frame_collect u_dut0 (
        .i_clk(clk), .i_rst_n(rst0_n), .i_uart_rxd(rxd0), .i_enable(en0),
        .o_valid(v0), .o_data(d0), .o_frame_err(fe0), .o_busy(b0)
    );

    uart_rx_frame_collect #(.CLK_DIV(5), .DATA_W(8), .LSB_FIRST(1), .STOP_BITS(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_uart_rxd(rxd1), .i_enable(en1),
        .o_valid(v1), .o_data(d1), .o_frame_err(fe1), .o_busy(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every delivered frame; flag any error indication outside a valid cycle.
    always @(negedge clk) begin
        if (v0 === 1'b1) begin
            gc0.push_back(cyc); gd0.push_back(64'(d0)); ge0.push_back(fe0);
        end else if (fe0 !== 1'b0) begin
            leak++;
        end
        if (v1 === 1'b1) begin
            gc1.push_back(cyc); gd1.push_back(64'(d1)); ge1.push_back(fe1);
        end else if (fe1 !== 1'b0) begin
            leak++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int d, input logic v);
        if (d == 0) rxd0 = v; else rxd1 = v;
    endtask

    task automatic set_en(input int d, input logic v);
        if (d == 0) en0 = v; else en1 = v;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_line(d, 1'b1);
        end
    endtask

    // mode 0: normal, 1: enable low for the whole frame, 2: enable dropped at bit 3,
    // 3: reset pulse in the middle of bit 4 (instance 1 only).
    task automatic send(input int d, input logic [63:0] val, input logic [1:0] stop_v,
                        input int gbit, input int goff, input int mode);
        int          cd, dw, sb, lsb, n0;
        logic        bits[$];
        logic        err;
        logic [63:0] mask;
        cd  = (d == 0) ? 16 : 5;
        dw  = (d == 0) ? 32 : 8;
        sb  = (d == 0) ? 1 : 2;
        lsb = (d == 0) ? 0 : 1;
        n0  = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(lsb != 0 ? val[i] : val[dw-1-i]);
        for (int s = 0; s < sb; s++) bits.push_back(stop_v[s]);
        if (mode == 1) set_en(d, 1'b0);
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < cd; c++) begin
                @(posedge clk); #1;
                if (k == 0 && c == 0) n0 = cyc;
                if (mode == 2 && k == 3 && c == 0) set_en(d, 1'b0);
                if (mode == 3 && d == 1 && k == 4 && c == cd / 2) begin
                    chk("busy_before_reset", 64'(b1), 64'd1);
                    rst1_n = 1'b0;
                    #1;
                    chk("rst_valid", 64'(v1), 64'd0);
                    chk("rst_data", 64'(d1), 64'd0);
                    chk("rst_ferr", 64'(fe1), 64'd0);
                    chk("rst_busy", 64'(b1), 64'd0);
                    rxd1 = 1'b1;
                    @(posedge clk); #1;
                    rst1_n = 1'b1;
                    return;
                end
                set_line(d, bits[k] ^ ((k == gbit && c == goff) ? 1'b1 : 1'b0));
            end
        end
        set_en(d, 1'b1);
        if (mode != 1) begin
            mask = (64'd1 << dw) - 64'd1;
            err  = 1'b0;
            for (int s = 0; s < sb; s++) if (!stop_v[s]) err = 1'b1;
            // Edge seen 2 cycles after the line falls; valid follows the last stop decision.
            if (d == 0) begin
                ec0.push_back(n0 + 2 + 1 + (dw + sb) * cd + cd / 2 + 2);
                ed0.push_back(val & mask); ee0.push_back(err);
            end else begin
                ec1.push_back(n0 + 2 + 1 + (dw + sb) * cd + cd / 2 + 2);
                ed1.push_back(val & mask); ee1.push_back(err);
            end
        end
    endtask

    task automatic check_sb();
        chk("n_valid0", 64'(gc0.size()), 64'(ec0.size()));
        while (gc0.size() > 0 && ec0.size() > 0) begin
            chk("vcyc0", 64'(gc0.pop_front()), 64'(ec0.pop_front()));
            chk("data0", gd0.pop_front(), ed0.pop_front());
            chk("ferr0", 64'(ge0.pop_front()), 64'(ee0.pop_front()));
        end
        chk("n_valid1", 64'(gc1.size()), 64'(ec1.size()));
        while (gc1.size() > 0 && ec1.size() > 0) begin
            chk("vcyc1", 64'(gc1.pop_front()), 64'(ec1.pop_front()));
            chk("data1", gd1.pop_front(), ed1.pop_front());
            chk("ferr1", 64'(ge1.pop_front()), 64'(ee1.pop_front()));
        end
        gc0.delete(); gd0.delete(); ge0.delete(); ec0.delete(); ed0.delete(); ee0.delete();
        gc1.delete(); gd1.delete(); ge1.delete(); ec1.delete(); ed1.delete(); ee1.delete();
    endtask

    initial begin
        int n;
        int bhigh;
        logic [1:0] sv;
        rst0_n = 1'b0; rst1_n = 1'b0;
        rxd0 = 1'b1; rxd1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid0", 64'(v0), 64'd0);
        chk("reset_data0", 64'(d0), 64'd0);
        chk("reset_ferr0", 64'(fe0), 64'd0);
        chk("reset_busy0", 64'(b0), 64'd0);
        chk("reset_data1", 64'(d1), 64'd0);
        chk("reset_busy1", 64'(b1), 64'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;

        // Idle line for 1000 cycles.
        bhigh = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (b0 !== 1'b0 || b1 !== 1'b0) bhigh++;
        end
        chk("idle_busy_cycles", 64'(bhigh), 64'd0);
        chk("idle_data0", 64'(d0), 64'd0);
        check_sb();

        // Reference frame, MSB first.
        send(0, 64'hA5C30F71, 2'b11, -1, 0, 0);
        idle(0, 48);
        check_sb();

        // Short low pulse: false start.
        @(posedge clk); #1;
        rxd0 = 1'b0;
        n = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("false_busy_at_edge", 64'(b0), 64'd0);
        @(posedge clk); #1;
        chk("false_busy_after_edge", 64'(b0), 64'd1);
        @(posedge clk); #1;
        rxd0 = 1'b1;
        while (cyc < n + 12) begin @(posedge clk); #1; end
        chk("false_busy_at_decision", 64'(b0), 64'd1);
        @(posedge clk); #1;
        chk("false_busy_cleared", 64'(b0), 64'd0);
        idle(0, 40);
        check_sb();

        // Framing error then recovery.
        send(0, 64'h12345678, 2'b00, -1, 0, 0);
        idle(0, 48);
        send(0, 64'h0000FFFF, 2'b11, -1, 0, 0);
        idle(0, 48);
        check_sb();

        // Glitch at the middle sample, then back-to-back frames.
        send(0, 64'hFFFFFFFF, 2'b11, 5, 9, 0);
        idle(0, 48);
        send(0, 64'h1, 2'b11, -1, 0, 0);
        send(0, 64'h2, 2'b11, -1, 0, 0);
        idle(0, 48);
        check_sb();

        // Enable low ignores a frame; dropping it mid-frame does not abort.
        send(0, 64'($urandom), 2'b11, -1, 0, 1);
        idle(0, 48);
        send(0, 64'($urandom), 2'b11, -1, 0, 2);
        idle(0, 48);
        check_sb();

        // Random frames on the default instance.
        for (int i = 0; i < 5; i++) begin
            sv = {1'b1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0};
            send(0, 64'($urandom), sv, int'($urandom_range(1, 32)), int'($urandom_range(0, 15)), 0);
            idle(0, 40);
        end
        check_sb();

        // Small instance: good frame, reset mid-frame, resend.
        send(1, 64'hA7, 2'b11, -1, 0, 0);
        idle(1, 20);
        send(1, 64'h3C, 2'b11, -1, 0, 3);
        idle(1, 40);
        check_sb();
        send(1, 64'h3C, 2'b11, -1, 0, 0);
        idle(1, 20);
        check_sb();

        // Random frames on the small instance, including stop-bit errors.
        for (int i = 0; i < 12; i++) begin
            sv[0] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            sv[1] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            send(1, 64'($urandom_range(0, 255)), sv, int'($urandom_range(1, 8)),
                 int'($urandom_range(0, 4)), 0);
            idle(1, 15);
        end
        check_sb();

        chk("ferr_outside_valid", 64'(leak), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
